// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, programmable baud divisor
// and registered one-cycle read data for the core's synchronous memory port.
module uart_tx_mmio #(
  parameter int                 REG_LEN     = 32,
  parameter logic [REG_LEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                 FIFO_DEPTH  = 8,
  parameter logic [15:0]        DEFAULT_DIV = 16'd434
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_LEN-1:0] addr,
  input  logic [REG_LEN-1:0] wdata,
  input  logic               we,
  input  logic [3:0]         be,
  output logic [REG_LEN-1:0] rdata,
  output logic               txd,
  output logic               irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             overflow;
  logic [15:0]      div;
  logic [15:0]      div_wr;
  logic [15:0]      tick;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  logic             hit;
  logic [1:0]       offset;
  logic             wr_data;
  logic             wr_div;
  logic             clr_ovf;
  logic             fifo_full;
  logic             fifo_empty;
  logic             bit_end;
  logic             pop;
  logic             push;
  logic             drop;
  logic             idle_next;
  logic [REG_LEN-1:0] status_word;
  logic             unused_bits;

  assign hit     = (addr[REG_LEN-1:4] == BASE_ADDR[REG_LEN-1:4]);
  assign offset  = addr[3:2];
  assign wr_data = hit && we && (offset == 2'd0) && be[0];
  assign clr_ovf = hit && we && (offset == 2'd1) && be[0] && wdata[3];
  assign wr_div  = hit && we && (offset == 2'd2) && (be[0] || be[1]);

  assign unused_bits = ^{addr[1:0], wdata[REG_LEN-1:16], be[3:2]};

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A bit period ends on the cycle the tick counter has run down to zero.
  assign bit_end = (state != IDLE) && (tick == '0);

  // The shifter takes a byte either from idle or straight out of a stop bit.
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push = wr_data && (!fifo_full || pop);
  assign drop = wr_data && fifo_full && !pop;

  assign idle_next = !pop && ((state == IDLE) || ((state == STOP) && bit_end));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_comb begin
    div_wr = div;
    if (be[0]) div_wr[7:0]  = wdata[7:0];
    if (be[1]) div_wr[15:8] = wdata[15:8];
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = fifo_full;
    status_word[1]    = fifo_empty;
    status_word[2]    = (state != IDLE);
    status_word[3]    = overflow;
    status_word[11:8] = 4'(count);
  end

  // Reads sample pre-write register state, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (!hit) begin
      rdata <= '0;
    end else begin
      case (offset)
        2'd1:    rdata <= status_word;
        2'd2:    rdata <= REG_LEN'(div);
        default: rdata <= '0;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wdata[7:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= DEFAULT_DIV;
    end else if (wr_div) begin
      div <= (div_wr == '0) ? 16'd1 : div_wr;
    end
  end

  // Transmit FSM; the divisor is only sampled at bit starts, so DIV writes apply at the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      irq     <= 1'b1;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      irq <= (count_next == '0) && idle_next;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= fifo_mem[rd_ptr];
            state <= START;
            txd   <= 1'b0;
            tick  <= div - 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= '0;
            tick    <= div - 1'b1;
          end else begin
            tick <= tick - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick <= div - 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg <= fifo_mem[rd_ptr];
              state <= START;
              txd   <= 1'b0;
              tick  <= div - 1'b1;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            tick <= tick - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a frame-level reference model predicts txd, irq
// and rdata for every cycle; a monitor pops and compares one cycle after each edge.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          D       = 8;
  localparam logic [15:0] DEF_DIV = 16'd434;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  uart_tx_mmio #(
    .REG_LEN(32), .BASE_ADDR(BASE), .FIFO_DEPTH(D), .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .be(be),
    .rdata(rdata), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        txd;
    logic        irq;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pending bytes, and position within the current frame
  // expressed as bits remaining (10..1) and clocks remaining in that bit.
  logic [7:0]  m_q[$];
  bit          m_busy;
  int          m_bits_left;
  int          m_clk_left;
  logic [7:0]  m_cur;
  bit          m_ovf;
  logic [15:0] m_div;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (m_q.size() == D);
    s[1]    = (m_q.size() == 0);
    s[2]    = m_busy;
    s[3]    = m_ovf;
    s[11:8] = 4'(m_q.size());
    return s;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_busy      = 0;
    m_bits_left = 0;
    m_clk_left  = 0;
    m_cur       = '0;
    m_ovf       = 0;
    m_div       = DEF_DIV;
  endtask

  task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                            input logic w, input logic [3:0] b);
    exp_t        e;
    bit          hit;
    int          off;
    bit          pop;
    int          pre;
    logic [15:0] nd;
    int          idx;
    hit = (a[31:4] == BASE[31:4]);
    off = int'(a[3:2]);
    if (r) begin
      m_reset();
      e.txd = 1'b1; e.irq = 1'b1; e.rdata = '0;
      exp_q.push_back(e);
      return;
    end
    e.rdata = '0;
    if (hit && off == 1) e.rdata = m_status();
    if (hit && off == 2) e.rdata = {16'h0, m_div};
    pre = m_q.size();
    pop = 0;
    if (m_busy) begin
      if (m_clk_left == 1) begin
        if (m_bits_left == 1) begin
          if (pre > 0) pop = 1;
          else m_busy = 0;
        end else begin
          m_bits_left--;
          m_clk_left = int'(m_div);
        end
      end else begin
        m_clk_left--;
      end
    end else if (pre > 0) begin
      pop = 1;
    end
    if (pop) begin
      m_cur       = m_q.pop_front();
      m_busy      = 1;
      m_bits_left = 10;
      m_clk_left  = int'(m_div);
    end
    if (hit && w && off == 1 && b[0] && wd[3]) m_ovf = 0;
    if (hit && w && off == 0 && b[0]) begin
      if (pre < D || pop) m_q.push_back(wd[7:0]);
      else m_ovf = 1;
    end
    if (hit && w && off == 2 && (b[0] || b[1])) begin
      nd = m_div;
      if (b[0]) nd[7:0] = wd[7:0];
      if (b[1]) nd[15:8] = wd[15:8];
      m_div = (nd == 0) ? 16'd1 : nd;
    end
    if (!m_busy) begin
      e.txd = 1'b1;
    end else begin
      idx = 10 - m_bits_left;
      if (idx == 0) e.txd = 1'b0;
      else if (idx == 9) e.txd = 1'b1;
      else e.txd = m_cur[idx-1];
    end
    e.irq = !m_busy && (m_q.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [3:0] b);
    @(negedge clk);
    rst = r; addr = a; wdata = wd; we = w; be = b;
    model_step(r, a, wd, w, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cyc(1'b0, a, d, 1'b1, b);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, a, '0, 1'b0, 4'h0);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("txd", {31'h0, txd}, {31'h0, e.txd});
      check("irq", {31'h0, irq}, {31'h0, e.irq});
      check("rdata", rdata, e.rdata);
    end
  end

  initial begin
    int k;
    m_reset();

    // Reset and default register values.
    cyc(1'b1, '0, '0, 1'b0, 4'h0);
    cyc(1'b1, '0, '0, 1'b0, 4'h0);
    rd(BASE + 32'h4);
    rd(BASE + 32'h8);
    rd(BASE + 32'h0);
    rd(BASE + 32'hC);
    idle(2);

    // Single 0xA5 frame at DIV=4.
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    wr(BASE + 32'h0, 32'hA5, 4'b0001);
    idle(45);
    rd(BASE + 32'h4);

    // Burst of 10 writes at DIV=2: FIFO fills, 10th overflows, then clear.
    wr(BASE + 32'h8, 32'd2, 4'b0011);
    for (int i = 0; i < 10; i++) wr(BASE, 32'h30 + i, 4'b0001);
    rd(BASE + 32'h4);
    wr(BASE + 32'h4, 32'h8, 4'b0001);
    rd(BASE + 32'h4);
    idle(200);

    // Full FIFO with a pop and a push in the same cycle.
    for (int i = 0; i < 9; i++) wr(BASE, 32'hC0 + i, 4'b0001);
    for (int i = 0; i < 60 && !(m_busy && m_bits_left == 1 && m_clk_left == 1 && m_q.size() == D); i++)
      idle(1);
    wr(BASE, 32'h5A, 4'b0001);
    rd(BASE + 32'h4);
    idle(200);

    // Divisor change in the middle of a DATA bit.
    wr(BASE + 32'h8, 32'd8, 4'b0011);
    wr(BASE, 32'h6B, 4'b0001);
    idle(28);
    wr(BASE + 32'h8, 32'd3, 4'b0011);
    idle(40);
    wr(BASE + 32'h8, 32'h0000_0000, 4'b0011);
    rd(BASE + 32'h8);
    wr(BASE + 32'h8, 32'h0000_0700, 4'b0010);
    rd(BASE + 32'h8);

    // Reset mid-DATA, then out-of-window accesses.
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    wr(BASE, 32'h3C, 4'b0001);
    wr(BASE, 32'h3D, 4'b0001);
    idle(12);
    cyc(1'b1, '0, '0, 1'b0, 4'h0);
    rd(BASE + 32'h4);
    rd(BASE + 32'h8);
    wr(32'h7FFF_FFF0, 32'h55, 4'hF);
    wr(32'h8000_0010, 32'h55, 4'hF);
    wr(32'h7FFF_FFF8, 32'h2, 4'hF);
    wr(32'h8000_0018, 32'h2, 4'hF);
    rd(32'h7FFF_FFF4);
    rd(32'h8000_0014);
    rd(BASE + 32'h4);
    rd(BASE + 32'h8);
    idle(3);

    // Randomized traffic with small divisors.
    wr(BASE + 32'h8, 32'd1, 4'b0011);
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 199);
      if (k == 0) begin
        cyc(1'b1, '0, '0, 1'b0, 4'h0);
        wr(BASE + 32'h8, 32'd2, 4'b0011);
      end else if (k < 50) begin
        wr(BASE, $urandom, 4'($urandom_range(0, 15)));
      end else if (k < 58) begin
        wr(BASE + 32'h8, 32'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
      end else if (k < 66) begin
        wr(BASE + 32'h4, $urandom, 4'($urandom_range(0, 15)));
      end else if (k < 72) begin
        wr(BASE + 32'hC, $urandom, 4'hF);
      end else if (k < 110) begin
        rd(BASE + {28'h0, 2'($urandom_range(0, 3)), 2'b00});
      end else if (k < 120) begin
        cyc(1'b0, ($urandom_range(0, 1) != 0) ? (BASE - 32'h10) : (BASE + 32'h10) + 32'($urandom_range(0, 15)),
            $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end
    idle(80);

    @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that sits directly downstream of the rysy core's single data/instruction memory port. It decodes the core's addr/we/be/wdata bus in a fixed address window, buffers written bytes in a small FIFO and serialises them as 8N1 frames on txd. Read data returns with one cycle of latency, matching the synchronous memory timing the core expects. A top-level mux ORs rdata with the RAM's read data.

Parameters:
REG_LEN, 32, bus data/address width
BASE_ADDR, 32'h8000_0000, window base; bits [3:0] must be zero; window is 16 bytes
FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2
DEFAULT_DIV, 16'd434, reset value of the baud divisor (clocks per bit)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
addr  in  REG_LEN  byte address from core
wdata  in  REG_LEN  write data from core
we  in  1  write enable
be  in  4  byte enables
rdata  out  REG_LEN  registered read data; 0 when the previous cycle's address was outside the window
txd  out  1  serial output, idle high
irq  out  1  high while FIFO empty and shifter idle

Behaviour:
- Clocking: single clock `clk`. Reset `rst` is synchronous and active-high. Hit = (addr[REG_LEN-1:4] == BASE_ADDR[REG_LEN-1:4]). Register offset = addr[3:2].
- Reset state:
  - txd=1, rdata=0, irq=1.
  - FIFO empty (rd/wr pointers 0, count 0), overflow=0.
  - div=DEFAULT_DIV, FSM=IDLE, bit counter=0.
  - Reset mid-frame aborts the frame immediately: txd=1 next cycle.
- Registers:
  - 0x0 DATA, write-only. Write with we=1 and be[0]=1 pushes wdata[7:0]. Reads return 0.
  - 0x4 STATUS, read: bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bit3 overflow (sticky), bits[11:8] count. Writing 1 to bit3 with be[0]=1 clears overflow; other bits are read-only.
  - 0x8 DIV, r/w, bits[15:0]. Each byte lane updates independently per be[1:0]. A written value of 0 is stored as 1.
  - 0xC reserved: reads 0, writes ignored.
- Read latency: rdata at cycle N+1 reflects register state at the end of cycle N for the addr presented in cycle N (reads have no side effects). A write and a read of the same register in one cycle returns the pre-write value.
- FIFO push/pop:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH. Count is held exactly, 0..FIFO_DEPTH.
- FSM (IDLE, START, DATA, STOP):
  - IDLE: if FIFO non-empty, pop into the shift register and go to START. txd=0 from the next cycle.
  - Each state/bit holds txd for exactly div clocks. A tick counter loads div-1 at each bit start and counts to 0.
  - START -> DATA. DATA sends 8 bits LSB first, then goes to STOP (txd=1).
  - At STOP end: if FIFO non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
  - Frame length is exactly 10*div clocks.
- DIV write during a frame: takes effect at the next bit boundary. The current bit's counter is not altered.
- irq = empty & (FSM==IDLE), registered with the FSM.
- Push into an empty FIFO while IDLE: the byte is popped the cycle after the push. The start bit appears 2 cycles after the write cycle.

Test Plan:
- Reset, then read 0x8000_0004 → next-cycle rdata=0x0000_0002 (empty). Read 0x8 → 434. txd=1, irq=1.
- DIV=4, write 0xA5 to DATA → txd low 2 cycles later for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then stop high for 4 clocks. Total 40 clocks; irq returns to 1 after stop.
- DIV=2, write 9 bytes back-to-back while busy: the first is popped immediately, the next 8 fill the FIFO (full=1, count=8). A 10th write sets overflow. All 9 frames are sent contiguously with no idle gap. Writing STATUS=0x8 clears overflow.
- FIFO full and a pop (end of a frame) in the same cycle as a write → write accepted, count stays 8, overflow stays 0.
- During a DATA bit with DIV=8, write DIV=3 → current bit lasts 8 clocks and subsequent bits last 3 clocks.
- Assert rst mid-DATA → txd=1, STATUS=0x2, DIV=434 on the following cycle. Accesses to 0x7FFF_FFF0 and 0x8000_0010 → rdata=0 and no state change.
